// File: rtl/spi_codeword_rx.sv
// -----------------------------------------------------------------------------
// spi_codeword_rx
//
// Front-end SPI receive stage. It samples an SPI mode-0 link (CPOL=0, CPHA=0,
// MSB first) in the system clock domain and collects 8-bit extended-Hamming
// codewords. Each completed codeword is presented zero-extended on data_out
// and held there until the next complete codeword, so the downstream decoder
// only sees changes at codeword boundaries.
//
// Optional feature macro: SPI_RX_ABORT_COUNT_EN
//   defined     -> abort_count counts partial codewords discarded when chip
//                  select is released mid-byte.
//   not defined -> no abort counter register; abort_count is tied to zero.
//                  Partial codewords are still discarded silently.
//
// Parameters:
//   DATA_WIDTH    (>= 8) width of data_out
//   SYNC_STAGES   (>= 2) flops per input synchronizer
//   COUNTER_WIDTH        width of frame_count / abort_count (wrapping)
//
// Ports:
//   clk          system clock, all logic on its rising edge
//   reset        synchronous active-high reset
//   spi_sclk     asynchronous SPI clock
//   spi_cs_n     asynchronous chip select, active low
//   spi_mosi     asynchronous serial data
//   data_out     {zeros, codeword[7:0]}, held between loads
//   frame_valid  one-cycle pulse when data_out loads a new codeword
//   frame_count  completed codewords, wraps
//   abort_count  discarded partial codewords, wraps (0 when feature absent)
//
// Latency: the 8th sclk rise at the pins shows up on frame_valid/data_out
// SYNC_STAGES+2 clk edges later (synchronizer, shift update, output load).
// -----------------------------------------------------------------------------
module spi_codeword_rx #(
  parameter int DATA_WIDTH    = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int COUNTER_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     spi_sclk,
  input  logic                     spi_cs_n,
  input  logic                     spi_mosi,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     frame_valid,
  output logic [COUNTER_WIDTH-1:0] frame_count,
  output logic [COUNTER_WIDTH-1:0] abort_count
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers. Reset levels match an idle link (sclk low, cs_n high,
  // mosi low) so leaving reset never fabricates an edge.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_reg;
  logic [SYNC_STAGES-1:0] cs_n_sync_reg;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_reg <= '0;
      cs_n_sync_reg <= '1;
      mosi_sync_reg <= '0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_sclk};
      cs_n_sync_reg <= {cs_n_sync_reg[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  logic sync_sclk;
  logic sync_cs_n;
  logic sync_mosi;

  assign sync_sclk = sclk_sync_reg[SYNC_STAGES-1];
  assign sync_cs_n = cs_n_sync_reg[SYNC_STAGES-1];
  assign sync_mosi = mosi_sync_reg[SYNC_STAGES-1];

  // One extra delayed copy for edge detection.
  logic sclk_dly_reg;
  logic cs_n_dly_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_dly_reg <= 1'b0;
      cs_n_dly_reg <= 1'b1;
    end else begin
      sclk_dly_reg <= sync_sclk;
      cs_n_dly_reg <= sync_cs_n;
    end
  end

  logic sclk_rise;
  logic cs_fall;
  logic cs_rise;

  assign sclk_rise = sync_sclk & ~sclk_dly_reg;
  assign cs_fall   = ~sync_cs_n & cs_n_dly_reg;
  assign cs_rise   = sync_cs_n & ~cs_n_dly_reg;

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t      state_reg, state_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  shift_reg, shift_next;
  // Set on the edge that shifts in bit 7; the output load happens one clk
  // later from the completed shift register.
  logic        load_pending_reg, load_pending_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      bit_cnt_reg      <= 3'd0;
      shift_reg        <= 8'd0;
      load_pending_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      bit_cnt_reg      <= bit_cnt_next;
      shift_reg        <= shift_next;
      load_pending_reg <= load_pending_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    bit_cnt_next      = bit_cnt_reg;
    shift_next        = shift_reg;
    load_pending_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // sclk activity is ignored while deselected.
        if (cs_fall) begin
          state_next   = ST_SHIFT;
          bit_cnt_next = 3'd0;
          shift_next   = 8'd0;
        end
      end

      ST_SHIFT: begin
        if (cs_rise) begin
          // Deselect wins over a coincident sclk edge; that edge is dropped,
          // so a byte it would have completed is never loaded.
          state_next   = ST_IDLE;
          bit_cnt_next = 3'd0;
        end else if (sclk_rise) begin
          shift_next   = {shift_reg[6:0], sync_mosi};
          // 3-bit counter wraps to 0, staying in SHIFT for back-to-back bytes.
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            load_pending_next = 1'b1;
          end
        end
      end

      default: begin
        state_next   = ST_IDLE;
        bit_cnt_next = 3'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register and frame statistics. data_out only moves on a load; a
  // repeated identical codeword still produces a frame_valid pulse.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]    data_out_reg;
  logic                     frame_valid_reg;
  logic [COUNTER_WIDTH-1:0] frame_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_reg    <= '0;
      frame_valid_reg <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      frame_valid_reg <= load_pending_reg;
      if (load_pending_reg) begin
        data_out_reg    <= DATA_WIDTH'(shift_reg);
        frame_count_reg <= frame_count_reg + 1'b1;
      end
    end
  end

  assign data_out    = data_out_reg;
  assign frame_valid = frame_valid_reg;
  assign frame_count = frame_count_reg;

`ifdef SPI_RX_ABORT_COUNT_EN
  // A deselect with a partial byte in flight is an abort. bit_cnt is 7 when a
  // coincident 8th edge is dropped, so that case is covered too. Reset
  // mid-byte clears the counter path and is not an abort.
  logic                     abort_event;
  logic [COUNTER_WIDTH-1:0] abort_count_reg;

  assign abort_event = (state_reg == ST_SHIFT) && cs_rise && (bit_cnt_reg != 3'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      abort_count_reg <= '0;
    end else if (abort_event) begin
      abort_count_reg <= abort_count_reg + 1'b1;
    end
  end

  assign abort_count = abort_count_reg;
`else
  assign abort_count = '0;
`endif

endmodule

// File: tb/tb_spi_codeword_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_codeword_rx
//
// Directed bench for spi_codeword_rx with default parameters. SPI is driven
// with 4 clk half-periods; outputs are sampled 1 time unit after the clk edge.
// -----------------------------------------------------------------------------
module tb_spi_codeword_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic [31:0] data_out;
  logic        frame_valid;
  logic [3:0]  frame_count;
  logic [3:0]  abort_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int fv_cycles    = 0;
  int fv_mark;

`ifdef SPI_RX_ABORT_COUNT_EN
  localparam logic [3:0] ABORT_EXP = 4'd1;
`else
  localparam logic [3:0] ABORT_EXP = 4'd0;
`endif

  always #5 clk = ~clk;

  spi_codeword_rx #(
    .DATA_WIDTH   (32),
    .SYNC_STAGES  (2),
    .COUNTER_WIDTH(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .data_out   (data_out),
    .frame_valid(frame_valid),
    .frame_count(frame_count),
    .abort_count(abort_count)
  );

  // Counts clk cycles with frame_valid high; every pulse must be one cycle.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_cycles <= fv_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    spi_mosi = b;
    tick(4);
    spi_sclk = 1'b1;
    tick(4);
    spi_sclk = 1'b0;
  endtask

  // Sends the n most significant bits of v, MSB first.
  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(v[i]);
  endtask

  task automatic cs_start();
    spi_cs_n = 1'b0;
    tick(4);
  endtask

  task automatic cs_end();
    tick(4);
    spi_cs_n = 1'b1;
    tick(6);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    tick(4);
    reset = 1'b0;
    tick(2);
  endtask

  initial begin
    reset    = 1'b1;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;

    // ---- reset state
    do_reset();
    $display("[TB] reset state");
    check("rst_data",  data_out,    32'h0);
    check("rst_fv",    frame_valid, 32'h0);
    check("rst_fc",    frame_count, 32'h0);
    check("rst_ac",    abort_count, 32'h0);

    // ---- single frame 0xB4 with exact latency (4 clk edges after 8th rise)
    cs_start();
    send_bits(8'hB4, 7);
    spi_mosi = 1'b0;          // bit 0 of 0xB4
    tick(4);
    spi_sclk = 1'b1;
    tick(3);
    check("b4_fv_early", frame_valid, 32'h0);
    tick(1);
    check("b4_fv",       frame_valid, 32'h1);
    check("b4_data",     data_out,    32'h0000_00B4);
    check("b4_fc",       frame_count, 32'h1);
    tick(1);
    check("b4_fv_1cyc",  frame_valid, 32'h0);
    check("b4_hold",     data_out,    32'h0000_00B4);
    tick(3);
    spi_sclk = 1'b0;
    cs_end();
    $display("[TB] frame 0xB4 data=0x%0h fc=%0d", data_out, frame_count);

    // ---- back-to-back 0x3C, 0xA5 in one CS frame
    do_reset();
    fv_mark = fv_cycles;
    cs_start();
    send_bits(8'h3C, 8);
    check("b2b_first", data_out, 32'h0000_003C);
    send_bits(8'hA5, 8);
    check("b2b_second", data_out, 32'h0000_00A5);
    cs_end();
    tick(10);
    check("b2b_hold",   data_out, 32'h0000_00A5);
    check("b2b_fc",     frame_count, 32'h2);
    check("b2b_pulses", 32'(fv_cycles - fv_mark), 32'h2);
    $display("[TB] frame 0x3C,0xA5 data=0x%0h fc=%0d", data_out, frame_count);

    // ---- abort after 5 bits, then a clean 0x0F
    fv_mark = fv_cycles;
    cs_start();
    send_bits(8'hC7, 5);
    cs_end();
    check("abort_pulses", 32'(fv_cycles - fv_mark), 32'h0);
    check("abort_data",   data_out,    32'h0000_00A5);
    check("abort_fc",     frame_count, 32'h2);
    check("abort_ac",     abort_count, 32'(ABORT_EXP));
    cs_start();
    send_bits(8'h0F, 8);
    cs_end();
    check("after_abort_data", data_out,    32'h0000_000F);
    check("after_abort_fc",   frame_count, 32'h3);
    $display("[TB] abort then 0x0F data=0x%0h ac=%0d", data_out, abort_count);

    // ---- 17 frames: 4-bit frame_count wraps to 1; last byte 17*13 = 0xDD
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      cs_start();
      send_bits(8'(i * 13), 8);
      cs_end();
    end
    check("wrap_fc",   frame_count, 32'h1);
    check("wrap_data", data_out,    32'h0000_00DD);
    $display("[TB] 17 frames fc=%0d data=0x%0h", frame_count, data_out);

    // ---- reset mid-byte, then 0xFF
    cs_start();
    send_bits(8'hFF, 4);
    reset    = 1'b1;
    spi_cs_n = 1'b1;
    tick(2);
    check("midrst_data", data_out,    32'h0);
    check("midrst_fv",   frame_valid, 32'h0);
    check("midrst_fc",   frame_count, 32'h0);
    check("midrst_ac",   abort_count, 32'h0);
    tick(4);
    reset = 1'b0;
    tick(4);
    cs_start();
    send_bits(8'hFF, 8);
    cs_end();
    check("postrst_data", data_out,    32'h0000_00FF);
    check("postrst_ac",   abort_count, 32'h0);
    check("postrst_fc",   frame_count, 32'h1);
    $display("[TB] reset mid-byte then 0xFF data=0x%0h ac=%0d", data_out, abort_count);

    // ---- sclk toggling with cs_n high is ignored; next frame still aligned
    fv_mark = fv_cycles;
    send_bits(8'h5A, 8);
    tick(4);
    check("csh_pulses", 32'(fv_cycles - fv_mark), 32'h0);
    check("csh_data",   data_out,    32'h0000_00FF);
    check("csh_fc",     frame_count, 32'h1);
    cs_start();
    send_bits(8'h81, 8);
    cs_end();
    check("csh_next_data", data_out,    32'h0000_0081);
    check("csh_next_fc",   frame_count, 32'h2);
    $display("[TB] sclk with cs high then 0x81 data=0x%0h fc=%0d", data_out, frame_count);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
